// File: rtl/loader_pkg.sv
// Shared definitions for the serial code loader: command codes, framing
// constants and the receive/response state encoding.
package loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;

  localparam logic [7:0] SYNC_DEF  = 8'hA5;
  localparam logic [7:0] ACK_DEF   = 8'h5A;
  localparam logic [7:0] NAK_DEF   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_RESP
  } state_e;

endpackage

// File: rtl/code_loader.sv
// Serial program loader: parses checksummed WRITE/RUN frames, writes payload
// into code memory, answers ACK/NAK and holds the CPU until a valid RUN.
module code_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W  = 12,
  parameter logic [7:0] SYNC    = SYNC_DEF,
  parameter logic [7:0] ACK     = ACK_DEF,
  parameter logic [7:0] NAK     = NAK_DEF,
  parameter int         TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        txData_q, txData_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [7:0]        memWdata_q, memWdata_d;
  logic              hold_q, hold_d;
  logic              isRun_q, isRun_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic              accept;
  logic [7:0]        sumNext;
  logic              inFrame;

  assign rx_ready  = (state_q != ST_RESP);
  assign accept    = rx_valid && rx_ready;
  assign sumNext   = sum_q + rx_data;
  assign inFrame   = (state_q != ST_IDLE) && (state_q != ST_RESP);

  assign tx_valid  = (state_q == ST_RESP);
  assign tx_data   = txData_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    txData_d   = txData_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    hold_d     = hold_q;
    isRun_d    = isRun_q;
    timer_d    = '0;

    // A stalled host abandons the frame silently; any accepted byte restarts the count.
    if (inFrame && !accept) begin
      timer_d = timer_q + TW'(1);
      if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d = ST_IDLE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && rx_data == SYNC) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (accept) begin
          sum_d = rx_data;
          if (rx_data == CMD_WRITE) begin
            isRun_d = 1'b0;
            hold_d  = 1'b1;
            state_d = ST_ADDR_H;
          end else if (rx_data == CMD_RUN) begin
            isRun_d = 1'b1;
            state_d = ST_CHK;
          end else begin
            txData_d = NAK;
            state_d  = ST_RESP;
          end
        end
      end
      ST_ADDR_H: begin
        if (accept) begin
          sum_d   = sumNext;
          addr_d  = ADDR_W'({rx_data, 8'h00});
          state_d = ST_ADDR_L;
        end
      end
      ST_ADDR_L: begin
        if (accept) begin
          sum_d   = sumNext;
          addr_d  = addr_q | ADDR_W'(rx_data);
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          sum_d   = sumNext;
          cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          sum_d      = sumNext;
          memWe_d    = 1'b1;
          memAddr_d  = addr_q;
          memWdata_d = rx_data;
          addr_d     = addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (accept) begin
          sum_d   = sumNext;
          state_d = ST_RESP;
          if (sumNext == 8'h00) begin
            txData_d = ACK;
            if (isRun_q) begin
              hold_d = 1'b0;
            end
          end else begin
            txData_d = NAK;
          end
        end
      end
      ST_RESP: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      txData_q   <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      hold_q     <= 1'b1;
      isRun_q    <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      txData_q   <= txData_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      hold_q     <= hold_d;
      isRun_q    <= isRun_d;
      timer_q    <= timer_d;
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: frames are driven byte by byte while expected
// memory writes and response bytes are queued and checked by negedge monitors.
module tb_code_loader;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        busy;

  int          testsRun = 0;
  int          failCount = 0;
  int          writeCount = 0;
  logic [19:0] wrQ[$];
  logic [7:0]  rspQ[$];

  always #5 clk = ~clk;

  code_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next queued write; a pulse wider than
  // one cycle or a spurious write lands on an empty queue and fails.
  always @(negedge clk) begin
    logic [19:0] expWr;
    if (rst_n && mem_we) begin
      writeCount++;
      if (wrQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'({mem_addr, mem_wdata}), 32'h0010_0000);
      end else begin
        expWr = wrQ.pop_front();
        checkOutput("memWrite", 32'({mem_addr, mem_wdata}), 32'(expWr));
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] expRsp;
    if (rst_n && tx_valid && tx_ready) begin
      if (rspQ.size() == 0) begin
        checkOutput("unexpectedResp", 32'(tx_data), 32'h0000_0100);
      end else begin
        expRsp = rspQ.pop_front();
        checkOutput("txResp", 32'(tx_data), 32'(expRsp));
      end
    end
  end

  // Offers one byte and returns #1 after the edge on which it was accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checkOutput("rxReadyWait", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendWrite(input logic [15:0] a, input int len, input logic [7:0] seed, input bit bad);
    logic [7:0] sum;
    logic [7:0] d;
    logic [7:0] chk;
    int         n;
    n   = (len == 0) ? 256 : len;
    sum = 8'h01 + a[15:8] + a[7:0] + 8'(len);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(a[15:8]);
    applyStimulus(a[7:0]);
    applyStimulus(8'(len));
    for (int i = 0; i < n; i++) begin
      d = seed + 8'(i * 17);
      wrQ.push_back({a[11:0] + 12'(i), d});
      sum = sum + d;
      applyStimulus(d);
    end
    chk = 8'h00 - sum;
    if (bad) chk = chk + 8'h01;
    rspQ.push_back(bad ? 8'hEE : 8'h5A);
    applyStimulus(chk);
  endtask

  task automatic sendRun();
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    rspQ.push_back(8'h5A);
    applyStimulus(8'hFE);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".rx_ready"},  32'(rx_ready),  32'd1);
    checkOutput({tag, ".tx_valid"},  32'(tx_valid),  32'd0);
    checkOutput({tag, ".tx_data"},   32'(tx_data),   32'd0);
    checkOutput({tag, ".mem_we"},    32'(mem_we),    32'd0);
    checkOutput({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
    checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, ".cpu_hold"},  32'(cpu_hold),  32'd1);
    checkOutput({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wcStart;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1);

    // Basic write and the same frame with a corrupted checksum.
    sendWrite(16'h0010, 3, 8'h11, 1'b0);
    idleCycles(2);
    checkOutput("holdAfterWrite", 32'(cpu_hold), 32'd1);
    sendWrite(16'h0010, 3, 8'h11, 1'b1);
    idleCycles(2);

    // RUN releases the CPU in the same cycle the response appears.
    sendRun();
    checkOutput("runTxValid", 32'(tx_valid), 32'd1);
    checkOutput("runHoldLow", 32'(cpu_hold), 32'd0);
    applyStimulus(8'hA5);
    checkOutput("holdLowBeforeCmd", 32'(cpu_hold), 32'd0);
    applyStimulus(8'h01);
    checkOutput("holdAfterCmdWrite", 32'(cpu_hold), 32'd1);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    wrQ.push_back({12'h200, 8'h77});
    applyStimulus(8'h77);
    rspQ.push_back(8'h5A);
    applyStimulus(8'h85);
    idleCycles(2);

    // Address wrap and ignored upper address bits.
    sendWrite(16'h0FFF, 2, 8'hAA, 1'b0);
    sendWrite(16'hF123, 1, 8'h5C, 1'b0);

    // Noise before a frame is discarded.
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    sendWrite(16'h0300, 2, 8'h01, 1'b0);
    idleCycles(2);

    // Unknown command is NAKed and leaves a released CPU released.
    sendRun();
    applyStimulus(8'hA5);
    rspQ.push_back(8'hEE);
    applyStimulus(8'h07);
    checkOutput("badCmdTxValid", 32'(tx_valid), 32'd1);
    checkOutput("badCmdHold", 32'(cpu_hold), 32'd0);
    idleCycles(2);

    // Timeout: still busy one cycle before the limit, idle exactly at it.
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    idleCycles(TIMEOUT - 1);
    checkOutput("timeoutBusyBefore", 32'(busy), 32'd1);
    idleCycles(1);
    checkOutput("timeoutBusyAfter", 32'(busy), 32'd0);
    checkOutput("timeoutNoTx", 32'(tx_valid), 32'd0);
    checkOutput("timeoutHold", 32'(cpu_hold), 32'd1);
    sendRun();
    idleCycles(2);

    // LEN of zero means 256 data bytes.
    wcStart = writeCount;
    sendWrite(16'h0100, 0, 8'h00, 1'b0);
    idleCycles(3);
    checkOutput("len0WriteCount", 32'(writeCount - wcStart), 32'd256);

    // Reset in the middle of the data phase.
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h20);
    applyStimulus(8'h05);
    wrQ.push_back({12'h020, 8'hC1});
    applyStimulus(8'hC1);
    wrQ.push_back({12'h021, 8'hC2});
    applyStimulus(8'hC2);
    idleCycles(1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1);
    sendWrite(16'h0040, 2, 8'h10, 1'b0);
    idleCycles(2);

    // Response back-pressure keeps tx stable and blocks reception.
    tx_ready = 1'b0;
    sendWrite(16'h0050, 1, 8'h99, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bpTxValid", 32'(tx_valid), 32'd1);
      checkOutput("bpTxData", 32'(tx_data), 32'h5A);
      checkOutput("bpRxReady", 32'(rx_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    idleCycles(4);
    checkOutput("bpIdle", 32'(busy), 32'd0);

    checkOutput("wrQueueDrained", 32'(wrQ.size()), 32'd0);
    checkOutput("rspQueueDrained", 32'(rspQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/code_loader.md
# code_loader

Serial program loader that fills the 8051 core's 4 KB code memory and controls the core's run/hold state. It parses a checksummed byte-stream framing protocol, writes payload bytes into the code-memory write port and answers each frame with an ACK or NAK byte. It holds the processor in reset until a valid RUN command arrives. It sits between a byte transport (UART receiver/transmitter) and the processor's code memory.

## Interface
- `ADDR_W`, 12, code-memory address width (4096 bytes)
- `SYNC`, 8'hA5, frame start byte
- `ACK`, 8'h5A, response for an accepted frame
- `NAK`, 8'hEE, response for a rejected frame
- `TIMEOUT`, 1000, idle cycles allowed between bytes inside a frame
- `clk` in 1: single clock; all logic on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `rx_data` in 8: received byte
- `rx_valid` in 1: `rx_data` valid
- `rx_ready` out 1: loader accepts a byte
- `tx_data` out 8: response byte
- `tx_valid` out 1: response valid
- `tx_ready` in 1: transport accepts the response
- `mem_we` out 1: code-memory write strobe, one cycle per byte
- `mem_addr` out ADDR_W: write address
- `mem_wdata` out 8: write data
- `cpu_hold` out 1: processor reset hold, 1 = held
- `busy` out 1: high in every state except IDLE

## Operation
- **Byte handshake:** a byte is taken on any cycle where `rx_valid && rx_ready`.
- **Response handshake:** the response byte completes on `tx_valid && tx_ready`.
- **Frames:**
  - WRITE: SYNC, 0x01, ADDR_H, ADDR_L, LEN, DATA×N, CHK.
  - RUN: SYNC, 0x02, CHK.
- **Checksum:** the 8-bit sum of all bytes from CMD through CHK must equal 0x00.
- **LEN:** N = LEN, except LEN = 0 means N = 256.
- **Address:** start address is {ADDR_H, ADDR_L}[ADDR_W-1:0]; upper bits are ignored. The address increments per data byte and wraps modulo 2^ADDR_W.
- **States:** IDLE, CMD, ADDR_H, ADDR_L, LEN, DATA, CHK, RESP.
  - IDLE: discards every byte except SYNC; SYNC → CMD.
  - CMD: 0x01 → ADDR_H and sets `cpu_hold` = 1. 0x02 → CHK. Any other value → RESP with NAK.
  - ADDR_H → ADDR_L → LEN → DATA. DATA → CHK after the N-th byte.
  - CHK: checksum OK → RESP with ACK; otherwise RESP with NAK. An ACKed RUN clears `cpu_hold`.
  - RESP: `tx_valid` is held with a stable `tx_data` until the handshake, then → IDLE. `rx_ready` = 0 in RESP only.
- **Data writes:** each byte is written as soon as it is accepted.
  - A later NAK does not undo writes already made.
  - The host must resend the frame.
- **Timeout:** in CMD..CHK, if no byte is accepted for TIMEOUT consecutive cycles → IDLE. No response is sent and `cpu_hold` is unchanged.
- **SYNC inside a frame:** treated as ordinary data; no resynchronisation mid-frame.
- **Reset values:** state IDLE, `rx_ready` 1, `tx_valid` 0, `tx_data` 0x00, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `busy` 0.
- **Reset mid-frame:** the partial frame is abandoned and all outputs take their reset values.

## Timing
- `mem_we`/`mem_addr`/`mem_wdata` are registered: the strobe is high exactly one cycle, in the cycle after the data-byte handshake.
- The maximum throughput of one byte per cycle is sustained in all receive states.
- `tx_valid` rises in the cycle after the CHK handshake, or after the CMD handshake for an unknown command.
- `cpu_hold`:
  - falls in the same cycle that `tx_valid` rises for an ACKed RUN;
  - rises in the cycle after the handshake of CMD byte 0x01.
- First byte accepted again in the cycle after the response handshake.
- Timeout counter: reset on every accepted byte. Width is clog2(TIMEOUT+1).

## Structure
- Shared package `loader_pkg`: the command codes CMD_WRITE = 8'h01 and CMD_RUN = 8'h02, the state enum, and the SYNC/ACK/NAK default constants.
- No sub-modules; single flat FSM with datapath.
- Top-level wiring: the code-memory write port is muxed into the processor's code memory, and `cpu_hold` is ORed into the processor reset.

## Test plan
- **Basic write:** A5 01 00 10 03 11 22 33 86 → writes 0x010=11, 0x011=22, 0x012=33, each with a one-cycle `mem_we`; tx 5A; `cpu_hold` stays 1.
- **Bad checksum:** same frame with CHK 87 → three writes still occur; tx EE.
- **RUN:**
  - A5 02 FE → tx 5A, `cpu_hold` falls.
  - A following A5 01 … → `cpu_hold` returns to 1 after the CMD byte.
- **Address wrap:** A5 01 0F FF 02 AA BB 8A → writes 0xFFF=AA then 0x000=BB; tx 5A.
- **Noise, bad command, timeout:**
  - 00 FF 3C then a valid frame → noise ignored, frame ACKed.
  - A5 07 → tx EE.
  - A5 01 then TIMEOUT idle cycles → IDLE with no tx.
- **LEN=0 and reset mid-frame:**
  - LEN 00 → exactly 256 writes.
  - `rst_n` low during DATA → all outputs take their reset values; the next frame is ACKed normally.
  - Back-pressure: `tx_ready` low for 5 cycles → `tx_valid`/`tx_data` held stable.
